// File: rtl/instruction_memory_loader_if.sv
// Instruction memory write port: one word per wr_en strobe at a byte address.
// The loader drives it (master); the instruction memory samples it (slave).
interface instruction_memory_loader_if #(
  parameter int unsigned NB_REG = 32
);
  logic [NB_REG-1:0] wr_data;
  logic [NB_REG-1:0] wr_addr;
  logic              wr_en;

  modport master (
    output wr_data,
    output wr_addr,
    output wr_en
  );

  modport slave (
    input wr_data,
    input wr_addr,
    input wr_en
  );
endinterface

// File: rtl/instruction_memory_loader.sv
// Assembles MSB-first instruction words from a received byte stream and writes them to
// instruction memory from address 0, stalling the CPU until done. Checksum stage: LOADER_CHECKSUM_EN.
module instruction_memory_loader #(
  parameter int unsigned         NB_REG    = 32,
  parameter int unsigned         NB_BYTE   = 8,
  parameter int unsigned         N_ADDR    = 2048,
  parameter logic [NB_BYTE-1:0]  CMD_LOAD  = 8'h4C,
  parameter logic [NB_REG-1:0]   HALT_WORD = 32'hFFFFFFFF
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [NB_BYTE-1:0]         i_byte,
  input  logic                       i_byte_valid,
  input  logic                       i_restart,
  instruction_memory_loader_if.master mem_wr,
  output logic                       o_loading,
  output logic                       o_cpu_valid,
  output logic                       o_overflow,
  output logic                       o_checksum_err
);

  localparam int unsigned BYTES_PER_WORD = NB_REG / NB_BYTE;
  localparam int unsigned BCW            = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int unsigned WCW            = $clog2(N_ADDR + 1);
  localparam logic [BCW-1:0] LAST_BYTE   = BCW'(BYTES_PER_WORD - 1);
  localparam logic [WCW-1:0] FULL_CNT    = WCW'(N_ADDR);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

  state_t              state_q, state_n;
  logic [NB_REG-1:0]   word_q, word_n;
  logic [BCW-1:0]      byte_cnt_q, byte_cnt_n;
  logic [WCW-1:0]      word_cnt_q, word_cnt_n;
  logic                wr_en_q, wr_en_n;
  logic [NB_REG-1:0]   wr_data_q, wr_data_n;
  logic [NB_REG-1:0]   wr_addr_q, wr_addr_n;
  logic                loading_q, loading_n;
  logic                cpu_valid_q, cpu_valid_n;
  logic                overflow_q, overflow_n;
  logic                halt_written;
  logic                mem_full;

`ifdef LOADER_CHECKSUM_EN
  logic [NB_BYTE-1:0]  csum_q, csum_n;
  logic                csum_err_q, csum_err_n;
`endif

  // The write issued last cycle decides whether loading ends; word_cnt already counts it.
  assign halt_written = wr_en_q && (wr_data_q == HALT_WORD);
  assign mem_full     = wr_en_q && !halt_written && (word_cnt_q == FULL_CNT);

  always_comb begin
    state_n    = state_q;
    word_n     = word_q;
    byte_cnt_n = byte_cnt_q;
    word_cnt_n = word_cnt_q;
    wr_en_n    = 1'b0;
    wr_data_n  = wr_data_q;
    wr_addr_n  = wr_addr_q;
    overflow_n = overflow_q;
`ifdef LOADER_CHECKSUM_EN
    csum_n     = csum_q;
    csum_err_n = csum_err_q;
`endif

    if (i_restart) begin
      // Restart outranks a same-cycle byte, so a partial or just-completed word is never written.
      state_n    = IDLE;
      word_n     = '0;
      byte_cnt_n = '0;
      overflow_n = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_err_n = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_byte_valid && (i_byte == CMD_LOAD)) begin
            state_n    = LOAD;
            word_n     = '0;
            byte_cnt_n = '0;
            word_cnt_n = '0;
`ifdef LOADER_CHECKSUM_EN
            csum_n     = '0;
`endif
          end
        end

        LOAD: begin
          if (halt_written) begin
`ifdef LOADER_CHECKSUM_EN
            // A byte arriving alongside the halt write is already the checksum byte.
            if (i_byte_valid) begin
              csum_err_n = (i_byte != csum_q);
              state_n    = DONE;
            end else begin
              state_n    = CHECK;
            end
`else
            state_n = DONE;
`endif
          end else if (mem_full) begin
            state_n    = DONE;
            overflow_n = 1'b1;
          end else if (i_byte_valid) begin
            word_n = {word_q[NB_REG-NB_BYTE-1:0], i_byte};
`ifdef LOADER_CHECKSUM_EN
            csum_n = csum_q ^ i_byte;
`endif
            if (byte_cnt_q == LAST_BYTE) begin
              byte_cnt_n = '0;
              wr_en_n    = 1'b1;
              wr_data_n  = word_n;
              wr_addr_n  = NB_REG'(word_cnt_q) << 2;
              word_cnt_n = word_cnt_q + WCW'(1);
            end else begin
              byte_cnt_n = byte_cnt_q + BCW'(1);
            end
          end
        end

`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (i_byte_valid) begin
            csum_err_n = (i_byte != csum_q);
            state_n    = DONE;
          end
        end
`endif

        DONE: begin
          state_n = DONE;
        end

        default: begin
          state_n = IDLE;
        end
      endcase
    end

    cpu_valid_n = (state_n == DONE);
`ifdef LOADER_CHECKSUM_EN
    loading_n   = (state_n == LOAD) || (state_n == CHECK);
`else
    loading_n   = (state_n == LOAD);
`endif
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      word_q      <= '0;
      byte_cnt_q  <= '0;
      word_cnt_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      wr_addr_q   <= '0;
      loading_q   <= 1'b0;
      cpu_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_n;
      word_q      <= word_n;
      byte_cnt_q  <= byte_cnt_n;
      word_cnt_q  <= word_cnt_n;
      wr_en_q     <= wr_en_n;
      wr_data_q   <= wr_data_n;
      wr_addr_q   <= wr_addr_n;
      loading_q   <= loading_n;
      cpu_valid_q <= cpu_valid_n;
      overflow_q  <= overflow_n;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      csum_q     <= '0;
      csum_err_q <= 1'b0;
    end else begin
      csum_q     <= csum_n;
      csum_err_q <= csum_err_n;
    end
  end

  assign o_checksum_err = csum_err_q;
`else
  assign o_checksum_err = 1'b0;
`endif

  assign mem_wr.wr_en   = wr_en_q;
  assign mem_wr.wr_data = wr_data_q;
  assign mem_wr.wr_addr = wr_addr_q;
  assign o_loading      = loading_q;
  assign o_cpu_valid    = cpu_valid_q;
  assign o_overflow     = overflow_q;

endmodule
